// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
// No logic here; sizes are resolved at elaboration time.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester beats in, FIFO write port out; master = requesters/FIFO side, slave = arbiter.
// Pure wiring, no latency; fifo_full is the only backpressure into the arbiter.
interface fifo_wr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      fifo_full;

  modport master (
    output req, req_data, req_last, fifo_full,
    input  gnt, fifo_wr_en, fifo_data_in
  );

  modport slave (
    input  req, req_data, req_last, fifo_full,
    output gnt, fifo_wr_en, fifo_data_in
  );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating-priority pick: first set req bit strictly after rr_last, wrapping around.
// Purely combinational; valid is low when no requester is asking.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Walk from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(rr_last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter into a sync FIFO; zero-cycle grant, stalls on fifo_full, bursts capped at MAX_BURST.
// FIFO_WR_ARB_STATS_EN adds a saturating stall_cnt output.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDX_W     = idx_w(NUM_REQ),
  localparam int CNT_W     = cnt_w(MAX_BURST)
) (
  input  logic                clk,
  input  logic                rst,
  fifo_wr_arb_if.slave        bus,
  output logic [IDX_W-1:0]    owner,
  output logic                locked
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [DATA_W-1:0] data_mux;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .rr_last (rr_last_q),
    .winner  (pick_idx),
    .valid   (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_last_q  <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    gnt_vec    = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (pick_vld && !bus.fifo_full) begin
            gnt_vec[pick_idx] = 1'b1;
            owner_d           = pick_idx;
            rr_last_d         = pick_idx;
            if (!bus.req_last[pick_idx] && (MAX_BURST > 1)) begin
              state_d    = LOCK;
              beat_cnt_d = CNT_W'(1);
            end
          end
        end
        LOCK: begin
          // A dropped req mid-burst means the owner gave up; free the bus without granting.
          if (!bus.req[owner_q]) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else if (!bus.fifo_full) begin
            gnt_vec[owner_q] = 1'b1;
            if (bus.req_last[owner_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
              state_d    = IDLE;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vec[i]) data_mux = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign bus.gnt          = gnt_vec;
  assign bus.fifo_wr_en   = |gnt_vec;
  assign bus.fifo_data_in = data_mux;
  assign owner            = owner_q;
  assign locked           = (state_q == LOCK);

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((|bus.req) && bus.fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus randomized bursts into a depth-4 FIFO model.
// A burst-level reference model is compared against the DUT every cycle.
module tb_fifo_wr_arb;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [1:0] owner;
  logic       locked;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fifo_wr_arb #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .owner  (owner),
    .locked (locked)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester sources: left = beats remaining in the current burst.
  int   left[NR];
  int   blen[NR];
  bit   refill[NR];
  int   seq[NR];
  bit   full_force;
  bit   fifo_mode;
  bit   rnd_mode;
  bit   drain;
  logic [7:0] act_q[$];
  logic [7:0] exp_q[$];

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]               = (left[i] > 0);
      bus.req_last[i]          = (left[i] == 1);
      bus.req_data[i*DW +: DW] = {i[1:0], seq[i][5:0]};
    end
    bus.fifo_full = fifo_mode ? (act_q.size() >= DEPTH) : full_force;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      left[i]   = 0;
      refill[i] = 1'b0;
      blen[i]   = 1;
    end
  endtask

  task automatic tick(output logic [3:0] g, output logic [1:0] o, output logic l);
    logic [31:0] a, e;
    @(negedge clk);
    g = bus.gnt;
    o = owner;
    l = locked;
    if (fifo_mode) begin
      if (act_q.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
        a = 32'(act_q.pop_front());
        e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
        chk("fifo_order", a, e);
      end
      if (bus.fifo_wr_en) begin
        chk("no_overrun", 32'(act_q.size() < DEPTH), 32'd1);
        act_q.push_back(bus.fifo_data_in);
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (g[i]) begin
        left[i]--;
        seq[i]++;
        if (left[i] == 0 && refill[i]) left[i] = blen[i];
      end
      if (rnd_mode) begin
        if (!g[i] && left[i] > 0 && $urandom_range(0, 63) == 0) left[i] = 0;
        if (left[i] == 0 && !refill[i] && $urandom_range(0, 3) == 0) left[i] = int'($urandom_range(1, 7));
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  // Reference model: tracks the open burst (owner, beats taken) and the round-robin pointer.
  int  m_own  = 0;
  int  m_last = NR - 1;
  int  m_beats = 0;
  bit  m_act  = 1'b0;

  always @(negedge clk) begin
    logic [3:0] eg;
    logic [7:0] ed;
    bit         found;
    int         j;
    eg    = '0;
    ed    = '0;
    found = 1'b0;
    j     = 0;
    if (!rst) begin
      if (m_act) begin
        if (bus.req[m_own] && !bus.fifo_full) eg[m_own] = 1'b1;
      end else if (!bus.fifo_full) begin
        for (int k = 1; k <= NR; k++) begin
          j = (m_last + k) % NR;
          if (!found && bus.req[j]) begin
            eg[j] = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NR; i++) if (eg[i]) ed = bus.req_data[i*DW +: DW];
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("wr_en", 32'(bus.fifo_wr_en), 32'(|eg));
    chk("data", 32'(bus.fifo_data_in), 32'(ed));
    chk("owner", 32'(owner), m_own);
    chk("locked", 32'(locked), 32'(m_act));
    if (fifo_mode && eg != 0) exp_q.push_back(ed);
    if (rst) begin
      m_act = 1'b0; m_own = 0; m_last = NR - 1; m_beats = 0;
    end else if (m_act) begin
      if (!bus.req[m_own]) m_act = 1'b0;
      else if (eg != 0) begin
        m_beats++;
        if (bus.req_last[m_own] || m_beats == MB) m_act = 1'b0;
      end
    end else if (eg != 0) begin
      for (int i = 0; i < NR; i++) if (eg[i]) begin m_own = i; m_last = i; end
      m_beats = 1;
      if (!bus.req_last[m_own] && m_beats < MB) m_act = 1'b1;
    end
  end

  initial begin
    logic [3:0] g;
    logic [1:0] o;
    logic       l;
    int         exp31[8];
    exp31 = '{1, 1, 1, 1, 2, 1, 1, 2};
    rst = 1'b1;
    full_force = 1'b0; fifo_mode = 1'b0; rnd_mode = 1'b0; drain = 1'b0;
    for (int i = 0; i < NR; i++) seq[i] = 0;
    clear_src();
    drive();
    repeat (3) tick(g, o, l);
    chk("reset_gnt", 32'(g), 32'd0);
    chk("reset_owner", 32'(o), 32'd0);
    chk("reset_locked", 32'(l), 32'd0);

    // Alternating single-beat requesters 0 and 2.
    rst = 1'b0;
    left[0] = 1; refill[0] = 1'b1;
    left[2] = 1; refill[2] = 1'b1;
    drive();
    tick(g, o, l); chk("rr_a", 32'(g), 32'h1);
    tick(g, o, l); chk("rr_b", 32'(g), 32'h4);
    tick(g, o, l); chk("rr_c", 32'(g), 32'h1);
    clear_src(); drive();
    repeat (2) tick(g, o, l);

    // Six-beat burst from 1 capped at four, requester 2 slots in between.
    left[1] = 6;
    left[2] = 1; refill[2] = 1'b1;
    drive();
    for (int k = 0; k < 8; k++) begin
      tick(g, o, l);
      chk("burst_seq", 32'(g), 32'd1 << exp31[k]);
    end
    clear_src(); drive();
    repeat (2) tick(g, o, l);

    // Stall mid-burst on owner 3.
    left[3] = 6;
    drive();
    tick(g, o, l); chk("lock3_first", 32'(g), 32'h8);
    full_force = 1'b1; drive();
    for (int k = 0; k < 3; k++) begin
      tick(g, o, l);
      chk("stall_gnt", 32'(g), 32'd0);
      chk("stall_owner", 32'(o), 32'd3);
      chk("stall_locked", 32'(l), 32'd1);
    end
    full_force = 1'b0; drive();
    for (int k = 0; k < 3; k++) begin
      tick(g, o, l);
      chk("resume_gnt", 32'(g), 32'h8);
      chk("resume_locked", 32'(l), 32'd1);
    end
    tick(g, o, l); chk("burst_cap_release", 32'(l), 32'd0);
    clear_src(); drive();
    repeat (3) tick(g, o, l);

    // Reset in the middle of a burst owned by 2.
    left[2] = 6;
    drive();
    tick(g, o, l); chk("mid_a", 32'(g), 32'h4);
    tick(g, o, l); chk("mid_b", 32'(g), 32'h4);
    rst = 1'b1; drive();
    tick(g, o, l); chk("rst_mid_gnt", 32'(g), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin left[i] = 1; refill[i] = 1'b1; end
    drive();
    tick(g, o, l);
    chk("post_rst_owner", 32'(o), 32'd0);
    chk("post_rst_locked", 32'(l), 32'd0);
    chk("post_rst_gnt", 32'(g), 32'h1);
    clear_src(); drive();
    repeat (2) tick(g, o, l);

`ifdef FIFO_WR_ARB_STATS_EN
    rst = 1'b1; drive();
    tick(g, o, l);
    rst = 1'b0; full_force = 1'b1;
    left[0] = 1; refill[0] = 1'b1;
    left[1] = 1; refill[1] = 1'b1;
    drive();
    repeat (10) tick(g, o, l);
    chk("stall_cnt", 32'(stall_cnt), 32'd10);
    full_force = 1'b0; clear_src(); drive();
    repeat (2) tick(g, o, l);
`endif

    // Random bursts into the depth-4 FIFO model.
    fifo_mode = 1'b1; rnd_mode = 1'b1;
    drive();
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        rst = 1'b1; drive();
        tick(g, o, l);
        rst = 1'b0; drive();
      end
      tick(g, o, l);
    end
    rnd_mode = 1'b0; drain = 1'b1;
    clear_src(); drive();
    repeat (20) tick(g, o, l);
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_act_empty", 32'(act_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..16).
REQ-002 SHALL have parameter DATA_W, default 8, beat width, equal to the downstream sync FIFO DATA_W.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have req input NUM_REQ, per-requester beat-valid.
REQ-006 SHALL have req_data input NUM_REQ*DATA_W, requester i data in slice [i*DATA_W +: DATA_W].
REQ-007 SHALL have req_last input NUM_REQ, beat is the final beat of requester's burst.
REQ-008 SHALL have gnt output NUM_REQ, one-hot or zero, beat accepted this cycle.
REQ-009 SHALL have fifo_wr_en output 1, FIFO write strobe.
REQ-010 SHALL have fifo_data_in output DATA_W, FIFO write data.
REQ-011 SHALL have fifo_full input 1, FIFO full flag.
REQ-012 SHALL have owner output IDX_W=max(1,clog2(NUM_REQ)), index of the locked or last-granted requester.
REQ-013 SHALL have locked output 1, high while in state LOCK.

Function
REQ-014 gnt SHALL be combinational from state, req, fifo_full (zero-cycle handshake); fifo_wr_en = |gnt; fifo_data_in = req_data slice of the granted requester, '0 when no grant.
REQ-015 No gnt SHALL assert while fifo_full=1; no beat is ever dropped or duplicated.
REQ-016 FSM states: IDLE, LOCK.
REQ-017 IDLE: winner = first requester with req=1 searching from (rr_last+1) mod NUM_REQ upward with wrap; if fifo_full=0, gnt[winner]=1, owner<=winner, rr_last<=winner.
REQ-018 IDLE -> LOCK when the granted beat has req_last=0 and MAX_BURST>1; beat_cnt<=1; otherwise stay IDLE.
REQ-019 LOCK: gnt[owner]=req[owner]&&!fifo_full; other requesters SHALL receive no grant.
REQ-020 LOCK -> IDLE when an accepted beat has req_last=1 or beat_cnt reaches MAX_BURST-1 at acceptance; beat_cnt<=0.
REQ-021 LOCK with req[owner]=0 SHALL release to IDLE next cycle with no grant that cycle (requester abandoned burst).
REQ-022 LOCK with fifo_full=1 SHALL hold state, owner, beat_cnt unchanged.
REQ-023 beat_cnt width clog2(MAX_BURST+1); SHALL never exceed MAX_BURST-1.
REQ-024 fifo_full rising in the same cycle as a pending req: no grant, rr_last unchanged, arbitration re-evaluated next cycle.

Reset
REQ-025 rst=1 at any clk edge, including mid-burst, SHALL force state IDLE, owner=0, rr_last=NUM_REQ-1 (requester 0 highest priority), beat_cnt=0, locked=0; gnt/fifo_wr_en are 0 while rst=1.

Configuration
REQ-026 Macro FIFO_WR_ARB_STATS_EN defined: output stall_cnt [15:0] SHALL count cycles with |req=1 and fifo_full=1, saturating at 16'hFFFF, reset to 0.
REQ-027 Macro undefined: port stall_cnt and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state enum (IDLE, LOCK) and the IDX_W/count-width helper function.
REQ-029 Sub-module fifo_rr_pick (combinational rotating-priority pick: req vector + rr_last -> winner index, valid) SHALL implement REQ-017 search.

Verification
REQ-030 req=4'b0101, req_last=4'b1111, fifo_full=0 after reset -> gnt 0001, then 0100, then 0001 on consecutive cycles.
REQ-031 req[1]=1, req_last[1]=0 for 6 beats, MAX_BURST=4, req[2]=1 -> requester 1 gets beats 1-4, requester 2 next, then requester 1 beats 5-6.
REQ-032 LOCK on owner 3 with fifo_full=1 for 3 cycles -> gnt=0, owner=3, beat_cnt held, burst resumes when fifo_full=0.
REQ-033 Connected to sync FIFO DEPTH=4, all 4 requesters streaming distinct data 8'hA0+i -> FIFO read order matches grant order, no loss, full never overrun.
REQ-034 rst=1 mid-burst (owner=2, beat_cnt=2) -> next cycle locked=0, owner=0; first grant after reset goes to requester 0 when all req=1.
REQ-035 FIFO_WR_ARB_STATS_EN defined, fifo_full=1 with req=4'b0011 for 10 cycles -> stall_cnt=10.
